my_pecell_rst_seq: RTL
======================

# my_pecell_rst_seq

Parametrised reset sequencer and clock-enable generator for the PE cell array. It takes the free-running `clk` and raw asynchronous `rst_n` and synchronises the reset release. It then releases `NUM_CH` per-channel resets in a staggered order after a programmable hold, and supports software-requested soft resets. It also produces divided per-channel clock enables, so PE channels run from one clock at reduced rates.

## Interface
- `NUM_CH`, 4, number of reset/enable channels (≥1)
- `SYNC_STAGES`, 2, reset-release synchroniser depth (≥2)
- `HOLD_CYCLES`, 16, cycles between synchronised release (or soft-reset end) and channel 0 release (≥1)
- `STAGGER`, 4, cycles between consecutive channel releases (≥1)
- `DIV_W`, 8, width of clock-enable divide ratio
- `clk  in  1  single clock, rising edge`
- `rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronised internally`
- `sw_rst_req  in  1  soft-reset request, sampled each edge`
- `sw_rst_len  in  8  soft-reset low time in cycles; 0 treated as 1`
- `div_ratio  in  DIV_W  enable period minus one`
- `ch_rst_n  out  NUM_CH  per-channel active-low reset`
- `ch_clk_en  out  NUM_CH  per-channel clock-enable pulse`
- `busy  out  1  high while any channel is held in reset`
- `done  out  1  one-cycle pulse when the last channel is released`

## Operation
- Reset values while `rst_n`=0 (applied asynchronously): `ch_rst_n`=0, `ch_clk_en`=0, `busy`=1, `done`=0, state=SYNC, all counters 0.
- FSM states: SYNC, HOLD, RELEASE, RUN, SOFT.
- SYNC → HOLD when the synchroniser output is high.
- HOLD counts `HOLD_CYCLES` edges, then goes to RELEASE.
- RELEASE sets `ch_rst_n[0]` on entry and sets `ch_rst_n[i]` `i*STAGGER` cycles later. It goes to RUN on the edge that sets `ch_rst_n[NUM_CH-1]`.
- `done` pulses on the edge that sets the last channel. `busy` falls on that same edge.
- RUN with `sw_rst_req`=1: on the sampling edge, all `ch_rst_n`←0, `busy`←1, and L=max(`sw_rst_len`,1) is latched; the FSM enters SOFT. SOFT holds for L cycles, then goes to HOLD.
- `sw_rst_req` is ignored in SYNC, HOLD, RELEASE and SOFT. No queuing.
- `rst_n` assertion in any state aborts immediately to reset values. A new release restarts from SYNC.
- Divider: counter `cnt` (DIV_W bits) runs whenever the state is not SYNC. A tick occurs when `cnt`==`div_q`.
  - On a tick, `cnt`←0 and `div_q`←`div_ratio`. Otherwise `cnt` increments.
  - `div_ratio` is sampled only at a tick. The value applies from the next period.
- `ch_clk_en[i]` is registered as tick AND `ch_rst_n[i]` (current value). It is never high while that channel is in reset.
- `div_ratio`=0 gives `ch_clk_en` high every cycle for released channels.
- Counter widths are `$clog2` of the largest count held, plus 1. Counters never wrap in normal operation.

## Timing
- Release edge index k counts from the first rising edge with `rst_n` high.
- Synchronised release occurs at edge `SYNC_STAGES`.
- `ch_rst_n[i]` rises at edge `SYNC_STAGES+HOLD_CYCLES+i*STAGGER`.
- Soft reset sampled at edge T: `ch_rst_n` low from T, and `ch_rst_n[i]` rises at `T+L+HOLD_CYCLES+i*STAGGER`.
- Enable period is `div_ratio+1` cycles. A new ratio takes effect one period after it is sampled.
- `NUM_CH`=1: `done` pulses at the channel 0 release edge.

## Configuration
- `PECELL_SW_RST_EN` defined: the SOFT state and `sw_rst_req`/`sw_rst_len` handling are compiled in, as described above.
- Not defined: the SOFT state is absent and both ports remain but are ignored. After release, RUN persists until `rst_n` is asserted.

## Structure
- Package `my_pecell_rst_pkg` holds:
  - the `rst_seq_state_e` enum (SYNC, HOLD, RELEASE, RUN, SOFT);
  - default constants `PECELL_SYNC_STAGES`, `PECELL_HOLD_CYCLES` and `PECELL_STAGGER`.
- One sub-module, `my_pecell_rst_sync`: a `SYNC_STAGES`-deep flop chain with asynchronous clear and synchronous release.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- Defaults, `rst_n` released before edge 1 → `ch_rst_n[0..3]` rise at edges 18/22/26/30; `done` pulses at 30; `busy` falls at 30.
- `div_ratio`=3 after release → each `ch_clk_en` pulses once every 4 cycles. Changing to 0 mid-period → every cycle, starting from the period after the next tick.
- `sw_rst_req` at RUN edge T=100 with `sw_rst_len`=5 → all `ch_rst_n` low at 100; ch0 rises at 121, ch3 at 133; a second request at 110 is ignored.
- `sw_rst_len`=0 → low time 1 cycle; ch0 rises at T+17.
- `rst_n` pulsed low during RELEASE (after ch1 released) → all outputs 0 asynchronously; full sequence repeats with identical offsets.
- Build without `PECELL_SW_RST_EN`, `sw_rst_req`=1 in RUN → no change to `ch_rst_n`; `busy` stays 0.

Source files
------------

// File: rtl/my_pecell_rst_pkg.sv
// Shared types and default constants for the PE-cell reset sequencer.
package my_pecell_rst_pkg;

   typedef enum logic [2:0] {
      SYNC,
      HOLD,
      RELEASE,
      RUN,
      SOFT
   } rst_seq_state_e;

   localparam int PECELL_SYNC_STAGES = 2;
   localparam int PECELL_HOLD_CYCLES = 16;
   localparam int PECELL_STAGGER     = 4;

   // Soft-reset low time is an 8-bit quantity.
   localparam int PECELL_LEN_W = 8;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/my_pecell_rst_sync.sv
// Reset-release synchroniser: asynchronous clear, release shifted in over
// SYNC_STAGES rising edges.
module my_pecell_rst_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic rst_n_sync
);

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("my_pecell_rst_sync: SYNC_STAGES must be >= 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_n_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/my_pecell_rst_seq.sv
// Staggered per-channel reset sequencer with divided clock enables.
// Optional soft-reset support is compiled in with `define PECELL_SW_RST_EN.
module my_pecell_rst_seq
   import my_pecell_rst_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = PECELL_SYNC_STAGES,
   parameter int HOLD_CYCLES = PECELL_HOLD_CYCLES,
   parameter int STAGGER     = PECELL_STAGGER,
   parameter int DIV_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sw_rst_req,
   input  logic [7:0]        sw_rst_len,
   input  logic [DIV_W-1:0]  div_ratio,
   output logic [NUM_CH-1:0] ch_rst_n,
   output logic [NUM_CH-1:0] ch_clk_en,
   output logic              busy,
   output logic              done
);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("my_pecell_rst_seq: NUM_CH must be >= 1");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("my_pecell_rst_seq: HOLD_CYCLES must be >= 1");
   end
   if (STAGGER < 1) begin : g_bad_stagger
      $error("my_pecell_rst_seq: STAGGER must be >= 1");
   end
   if (DIV_W < 1) begin : g_bad_div_w
      $error("my_pecell_rst_seq: DIV_W must be >= 1");
   end

   // One phase counter serves HOLD, RELEASE and SOFT; size it for the longest.
   localparam int REL_MAX = (NUM_CH - 1) * STAGGER;
   localparam int CNT_MAX = max2(max2(HOLD_CYCLES, REL_MAX), (1 << PECELL_LEN_W) - 1);
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_MAX);

   rst_seq_state_e    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
   logic [NUM_CH-1:0] en_q, en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              rst_n_sync;
   logic              enter_release;
   logic              tick;

   my_pecell_rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .rst_n_sync (rst_n_sync)
   );

`ifdef PECELL_SW_RST_EN
   logic [PECELL_LEN_W-1:0] len_q, len_d;
`else
   logic unused_sw_rst;
   assign unused_sw_rst = ^{sw_rst_req, sw_rst_len};
`endif

   // NOTE: every always_comb output gets a default first so no path leaves
   // a signal unassigned and infers a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ch_rst_n_d    = ch_rst_n_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      enter_release = 1'b0;
`ifdef PECELL_SW_RST_EN
      len_d         = len_q;
`endif

      unique case (state_q)
         SYNC: begin
            if (rst_n_sync) begin
               if (HOLD_CYCLES == 1) begin
                  enter_release = 1'b1;
               end else begin
                  state_d = HOLD;
                  cnt_d   = CNT_W'(1);
               end
            end
         end

         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               enter_release = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RELEASE: begin
            cnt_d = cnt_q + 1'b1;
            for (int i = 1; i < NUM_CH; i++) begin
               if (cnt_d == CNT_W'(i * STAGGER)) begin
                  ch_rst_n_d[i] = 1'b1;
               end
            end
            if (cnt_d == REL_LAST) begin
               state_d = RUN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end

         RUN: begin
`ifdef PECELL_SW_RST_EN
            if (sw_rst_req) begin
               state_d    = SOFT;
               ch_rst_n_d = '0;
               busy_d     = 1'b1;
               cnt_d      = '0;
               len_d      = (sw_rst_len == '0) ? PECELL_LEN_W'(1) : sw_rst_len;
            end
`endif
         end

         SOFT: begin
`ifdef PECELL_SW_RST_EN
            // Low time elapses one edge after the counter reaches L.
            if (cnt_q == {{(CNT_W-PECELL_LEN_W){1'b0}}, len_q}) begin
               if (HOLD_CYCLES == 1) begin
                  enter_release = 1'b1;
               end else begin
                  state_d = HOLD;
                  cnt_d   = CNT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`else
            state_d = SYNC;
`endif
         end

         default: state_d = SYNC;
      endcase

      if (enter_release) begin
         ch_rst_n_d[0] = 1'b1;
         cnt_d         = '0;
         if (NUM_CH == 1) begin
            state_d = RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            state_d = RELEASE;
         end
      end
   end

   always_comb begin
      tick      = (state_q != SYNC) && (div_cnt_q == div_q);
      div_cnt_d = div_cnt_q;
      div_d     = div_q;
      if (state_q != SYNC) begin
         if (tick) begin
            div_cnt_d = '0;
            div_d     = div_ratio;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
      // Gating with the next value too keeps the enable low on a soft-reset edge.
      en_d = {NUM_CH{tick}} & ch_rst_n_q & ch_rst_n_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SYNC;
         cnt_q      <= '0;
         ch_rst_n_q <= '0;
         en_q       <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         div_cnt_q  <= '0;
         div_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ch_rst_n_q <= ch_rst_n_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_cnt_q  <= div_cnt_d;
         div_q      <= div_d;
      end
   end

`ifdef PECELL_SW_RST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0;
      end else begin
         len_q <= len_d;
      end
   end
`endif

   assign ch_rst_n  = ch_rst_n_q;
   assign ch_clk_en = en_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
